aes_round_sequencer: RTL

Iterative AES-256 encryption engine controller. It accepts one plaintext/key pair through a valid/ready handshake and time-multiplexes a single `encryption_rounds` datapath across rounds 1..13. It then applies the final round (`sub_bytes`/`shift_rows`/`add_round_key`, no MixColumns) and presents the ciphertext through a valid/ready handshake. It is the area-reduced alternative to the fully unrolled combinational encryptor and sits between the chip's host interface and the AES primitives.

---
 rtl/aes_seq_pkg.sv | 57 +++++
 rtl/aes_primitives.sv | 91 +++++++++
 rtl/aes_round_key_select.sv | 14 +
 rtl/aes_round_sequencer.sv | 107 ++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// Shared state type, sizes, round-key slicing and GF(2^8) byte helpers for the
// iterative AES-256 sequencer and the AES primitives it reuses.
package aes_seq_pkg;
   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} aes_seq_state_e;

   localparam int NUM_ROUNDS = 14;
   localparam int BLK_W      = 128;
   localparam int KEY_W      = 256;
   localparam int RK_CHAIN_W = 1920;

   function automatic logic [BLK_W-1:0] rk_sel(input logic [RK_CHAIN_W-1:0] chain,
                                               input logic [3:0] r);
      logic [BLK_W-1:0] rk;
      rk = '0;
      for (int i = 0; i <= NUM_ROUNDS; i++)
         if (int'(r) == i) rk = chain[RK_CHAIN_W-1-i*BLK_W -: BLK_W];
      return rk;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (0 maps to 0), then the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] inv;
      logic [7:0] sq;
      inv = 8'h01;
      sq  = a;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] blk_byte(input logic [BLK_W-1:0] blk, input int idx);
      return blk[BLK_W-1-8*idx -: 8];
   endfunction
endpackage

// File: rtl/aes_primitives.sv
// AES building blocks: sub_bytes, shift_rows, add_round_key, one full round
// (encryption_rounds) and the AES-256 key expansion. All purely combinational.
module sub_bytes
   import aes_seq_pkg::*;
(
   input  logic [BLK_W-1:0] data_i,
   output logic [BLK_W-1:0] data_o
);
   always_comb begin
      data_o = '0;
      for (int i = 0; i < 16; i++) data_o[BLK_W-1-8*i -: 8] = sbox(blk_byte(data_i, i));
   end
endmodule

module shift_rows
   import aes_seq_pkg::*;
(
   input  logic [BLK_W-1:0] data_i,
   output logic [BLK_W-1:0] data_o
);
   // Byte 4*c+r is row r of column c; row r rotates left by r columns.
   always_comb begin
      data_o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            data_o[BLK_W-1-8*(4*c+r) -: 8] = blk_byte(data_i, 4*((c+r)%4) + r);
   end
endmodule

module add_round_key
   import aes_seq_pkg::*;
(
   input  logic [BLK_W-1:0] state_i,
   input  logic [BLK_W-1:0] round_key_i,
   output logic [BLK_W-1:0] state_o
);
   assign state_o = state_i ^ round_key_i;
endmodule

module encryption_rounds
   import aes_seq_pkg::*;
(
   input  logic [BLK_W-1:0] state_i,
   input  logic [BLK_W-1:0] round_key_i,
   output logic [BLK_W-1:0] state_o
);
   logic [BLK_W-1:0] sb, sr, mc;

   sub_bytes     u_sb  (.data_i(state_i), .data_o(sb));
   shift_rows    u_sr  (.data_i(sb), .data_o(sr));
   add_round_key u_ark (.state_i(mc), .round_key_i(round_key_i), .state_o(state_o));

   always_comb begin
      mc = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            mc[BLK_W-1-8*(4*c+r) -: 8] = xtime(blk_byte(sr, 4*c+r))
                                       ^ xtime(blk_byte(sr, 4*c+(r+1)%4))
                                       ^ blk_byte(sr, 4*c+(r+1)%4)
                                       ^ blk_byte(sr, 4*c+(r+2)%4)
                                       ^ blk_byte(sr, 4*c+(r+3)%4);
   end
endmodule

module key_expansion
   import aes_seq_pkg::*;
(
   input  logic [KEY_W-1:0]      key_i,
   output logic [RK_CHAIN_W-1:0] chain_o
);
   always_comb begin : expand
      logic [31:0] w [4*(NUM_ROUNDS+1)];
      logic [31:0] tmp;
      logic [7:0]  rcon;
      rcon    = 8'h01;
      tmp     = '0;
      chain_o = '0;
      for (int i = 0; i < 8; i++) w[i] = key_i[KEY_W-1-32*i -: 32];
      for (int i = 8; i < 4*(NUM_ROUNDS+1); i++) begin
         tmp = w[i-1];
         if (i % 8 == 0) begin
            tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
            rcon = xtime(rcon);
         end else if (i % 8 == 4) begin
            tmp = sub_word(tmp);
         end
         w[i] = w[i-8] ^ tmp;
      end
      for (int i = 0; i < 4*(NUM_ROUNDS+1); i++) chain_o[RK_CHAIN_W-1-32*i -: 32] = w[i];
   end
endmodule

// File: rtl/aes_round_key_select.sv
// Expands the held cipher key and picks the round key for the current round.
module aes_round_key_select
   import aes_seq_pkg::*;
(
   input  logic [KEY_W-1:0] key_i,
   input  logic [3:0]       round_i,
   output logic [BLK_W-1:0] rk_o
);
   logic [RK_CHAIN_W-1:0] chain;

   key_expansion u_kexp (.key_i(key_i), .chain_o(chain));

   assign rk_o = rk_sel(chain, round_i);
endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-256: accept edge + 13 round edges + 1 final edge, ciphertext held until out_ready_i.
// AES_SEQ_B2B_EN lets a new pair be accepted on the same edge as the output handshake.
module aes_round_sequencer
   import aes_seq_pkg::*;
(
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [127:0] plaintext_i,
   input  logic [255:0] key_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [127:0] ciphertext_o,
   output logic         busy_o,
   output logic [3:0]   round_o
);
   aes_seq_state_e   fsm_q, fsm_d;
   logic [3:0]       round_q, round_d;
   logic [BLK_W-1:0] state_q, state_d, ct_q, ct_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             out_vld_q, out_vld_d;
   logic [BLK_W-1:0] rk, round_out, init_out, final_sb, final_sr, final_out;
   logic             accept, out_hs;

   aes_round_key_select u_rks (.key_i(key_q), .round_i(round_q), .rk_o(rk));

   add_round_key     u_init  (.state_i(plaintext_i), .round_key_i(key_i[KEY_W-1 -: BLK_W]),
                              .state_o(init_out));
   encryption_rounds u_round (.state_i(state_q), .round_key_i(rk), .state_o(round_out));
   sub_bytes         u_fsb   (.data_i(state_q), .data_o(final_sb));
   shift_rows        u_fsr   (.data_i(final_sb), .data_o(final_sr));
   add_round_key     u_fark  (.state_i(final_sr), .round_key_i(rk), .state_o(final_out));

`ifdef AES_SEQ_B2B_EN
   assign in_ready_o = (fsm_q == IDLE) | ((fsm_q == DONE) & out_ready_i);
`else
   assign in_ready_o = (fsm_q == IDLE);
`endif

   assign accept       = in_valid_i & in_ready_o & ~flush_i;
   assign out_hs       = out_vld_q & out_ready_i & ~flush_i;
   assign out_valid_o  = out_vld_q;
   assign ciphertext_o = ct_q;
   assign busy_o       = (fsm_q == ROUND) | (fsm_q == FINAL);
   assign round_o      = round_q;

   always_comb begin
      fsm_d     = fsm_q;
      round_d   = round_q;
      state_d   = state_q;
      key_d     = key_q;
      ct_d      = ct_q;
      out_vld_d = out_vld_q;
      case (fsm_q)
         ROUND: begin
            state_d = round_out;
            round_d = round_q + 4'd1;
            if (round_q == 4'(NUM_ROUNDS - 1)) fsm_d = FINAL;
         end
         FINAL: begin
            ct_d      = final_out;
            out_vld_d = 1'b1;
            round_d   = '0;
            fsm_d     = DONE;
         end
         DONE: begin
            if (out_hs) begin
               out_vld_d = 1'b0;
               fsm_d     = IDLE;
            end
         end
         default: ;
      endcase
      // In DONE this only fires with the back-to-back option, on top of out_hs.
      if (accept) begin
         key_d   = key_i;
         state_d = init_out;
         round_d = 4'd1;
         fsm_d   = ROUND;
      end
      if (flush_i) begin
         fsm_d     = IDLE;
         out_vld_d = 1'b0;
         round_d   = '0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         fsm_q     <= IDLE;
         round_q   <= '0;
         state_q   <= '0;
         key_q     <= '0;
         ct_q      <= '0;
         out_vld_q <= 1'b0;
      end else begin
         fsm_q     <= fsm_d;
         round_q   <= round_d;
         state_q   <= state_d;
         key_q     <= key_d;
         ct_q      <= ct_d;
         out_vld_q <= out_vld_d;
      end
   end
endmodule
